// File: rtl/vga_timing_pkg.sv
// Shared constants and helpers for the VGA raster timing generator.
// Holds the 640x480@60 default timing, derived totals, sync window helpers
// and the sync polarity helper.
package vga_timing_pkg;

    // Position counters are 10 bits, so a line or frame may be at most 1024 long.
    localparam int POS_W     = 10;
    localparam int MAX_TOTAL = 1 << POS_W;

    typedef logic [POS_W-1:0] pos_t;
    typedef logic [POS_W:0]   pos_ext_t;

    // 640x480@60 timing (800x525 total).
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam int DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    // Total period of one axis: active + front porch + sync + back porch.
    function automatic int axis_total(input int active, input int fp, input int sync_w, input int bp);
        return active + fp + sync_w + bp;
    endfunction

    // First position of the sync pulse.
    function automatic int sync_start(input int active, input int fp);
        return active + fp;
    endfunction

    // Last position of the sync pulse (inclusive).
    function automatic int sync_end(input int active, input int fp, input int sync_w);
        return active + fp + sync_w - 1;
    endfunction

    // Converts a logical "sync asserted" flag into the pin level.
    function automatic logic sync_level(input logic asserted, input logic neg);
        return asserted ^ neg;
    endfunction

endpackage

// File: rtl/vga_timing_gen_wrap_counter.sv
// Modulo counter used for both raster axes: advances on inc and returns to
// zero after LAST. count_next exposes the value the register takes on the
// coming edge so downstream decode can be registered in step with the count.
module wrap_counter #(
    parameter int WIDTH = 10,
    parameter int LAST  = 799
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] count_next,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] LAST_V = WIDTH'(LAST);

    // Next value: wrap at the terminal value, otherwise step when enabled.
    always_comb begin
        wrap       = inc && (count == LAST_V);
        count_next = count;
        if (wrap) begin
            count_next = '0;
        end else if (inc) begin
            count_next = count + 1'b1;
        end
    end

    // Count register with synchronous reset to zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel position, syncs, active-video flag and
// line/frame strobes, all registered and describing the same pixel.
// Optional feature: define VGA_TIMING_FRAME_CNT_EN to add the 8-bit frame
// counter output `frame`.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit SYNC_NEG = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ce,
    output pos_t       x_px,
    output pos_t       y_px,
    output logic       hsync,
    output logic       vsync,
    output logic       activevideo,
    output logic       line_start,
    output logic       frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    output logic [7:0] frame
`endif
);

    localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_bad_total
        $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
    end

    localparam pos_t     HS_START = pos_t'(sync_start(H_ACTIVE, H_FP));
    localparam pos_t     HS_END   = pos_t'(sync_end(H_ACTIVE, H_FP, H_SYNC));
    localparam pos_t     VS_START = pos_t'(sync_start(V_ACTIVE, V_FP));
    localparam pos_t     VS_END   = pos_t'(sync_end(V_ACTIVE, V_FP, V_SYNC));
    // Active limits use one extra bit so an active width of 1024 still compares correctly.
    localparam pos_ext_t H_ACT_X  = pos_ext_t'(H_ACTIVE);
    localparam pos_ext_t V_ACT_X  = pos_ext_t'(V_ACTIVE);

    pos_t x_next;
    pos_t y_next;
    logic h_wrap;
    logic v_wrap;
    logic hs_on;
    logic vs_on;
    logic av_on;

    wrap_counter #(
        .WIDTH (POS_W),
        .LAST  (H_TOTAL - 1)
    ) u_h_cnt (
        .clk        (clk),
        .reset      (reset),
        .inc        (ce),
        .count      (x_px),
        .count_next (x_next),
        .wrap       (h_wrap)
    );

    // The vertical axis steps only when a line completes.
    wrap_counter #(
        .WIDTH (POS_W),
        .LAST  (V_TOTAL - 1)
    ) u_v_cnt (
        .clk        (clk),
        .reset      (reset),
        .inc        (h_wrap),
        .count      (y_px),
        .count_next (y_next),
        .wrap       (v_wrap)
    );

    // Decode of the pixel the counters move to on this edge.
    always_comb begin
        hs_on = (x_next >= HS_START) && (x_next <= HS_END);
        vs_on = (y_next >= VS_START) && (y_next <= VS_END);
        av_on = ({1'b0, x_next} < H_ACT_X) && ({1'b0, y_next} < V_ACT_X);
    end

    // Decode registers; strobes come from the wrap events, since with ce high
    // the position reaches x=0 only through a line wrap and (0,0) only through
    // a frame wrap. With ce low everything holds, strobes included.
    always_ff @(posedge clk) begin
        if (reset) begin
            hsync       <= sync_level(1'b0, SYNC_NEG);
            vsync       <= sync_level(1'b0, SYNC_NEG);
            activevideo <= 1'b1;
            line_start  <= 1'b1;
            frame_start <= 1'b1;
        end else if (ce) begin
            hsync       <= sync_level(hs_on, SYNC_NEG);
            vsync       <= sync_level(vs_on, SYNC_NEG);
            activevideo <= av_on;
            line_start  <= h_wrap;
            frame_start <= v_wrap;
        end
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    // Frame counter: steps on each (H_TOTAL-1, V_TOTAL-1) -> (0,0) transition.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame <= '0;
        end else if (v_wrap) begin
            frame <= frame + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen: a reduced-timing instance (20x12 total) for
// frame-level corners, plus a default 640x480@60 instance checked over its
// first line and into the second.
module tb_vga_timing_gen;

  // Reduced timing: hsync x 12..14, active x<10; vsync y 8..9, active y<6.
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ce = 1'b0;
  logic [9:0] sx, sy, dx, dy;
  logic       shs, svs, sav, sls, sfs;
  logic       dhs, dvs, dav, dls, dfs;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [7:0] sframe, dframe;
`endif

  int errors = 0;
  int checks = 0;

  // Reference positions and frame count, advanced by tick().
  int smx = 0, smy = 0, dmx = 0, dmy = 0, mframe = 0;

  logic [31:0] exp_q[$];

  typedef struct {
    logic r;
    logic c;
    int   x;
    int   y;
    logic hs;
    logic vs;
    logic av;
    logic ls;
    logic fs;
  } vec_t;

  vec_t vecs[9];

  // ---------------- clock / watchdog ----------------
  initial forever #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  // ---------------- DUTs ----------------
  vga_timing_gen #(
    .H_ACTIVE(10), .H_FP(2), .H_SYNC(3), .H_BP(5),
    .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2),
    .SYNC_NEG(1'b1)
  ) dut_s (
    .clk(clk), .reset(reset), .ce(ce),
    .x_px(sx), .y_px(sy), .hsync(shs), .vsync(svs),
    .activevideo(sav), .line_start(sls), .frame_start(sfs)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frame(sframe)
`endif
  );

  vga_timing_gen dut_d (
    .clk(clk), .reset(reset), .ce(ce),
    .x_px(dx), .y_px(dy), .hsync(dhs), .vsync(dvs),
    .activevideo(dav), .line_start(dls), .frame_start(dfs)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frame(dframe)
`endif
  );

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] pack(input int x, input int y, input logic hs, input logic vs,
                                       input logic av, input logic ls, input logic fs);
    return {7'd0, 10'(x), 10'(y), hs, vs, av, ls, fs};
  endfunction

  function automatic logic [31:0] exp_s(input int x, input int y);
    return pack(x, y, !(x >= 12 && x <= 14), !(y >= 8 && y <= 9),
                (x < 10) && (y < 6), x == 0, (x == 0) && (y == 0));
  endfunction

  function automatic logic [31:0] exp_d(input int x, input int y);
    return pack(x, y, !(x >= 656 && x <= 751), !(y >= 490 && y <= 491),
                (x < 640) && (y < 480), x == 0, (x == 0) && (y == 0));
  endfunction

  function automatic logic [31:0] act_s();
    return {7'd0, sx, sy, shs, svs, sav, sls, sfs};
  endfunction

  function automatic logic [31:0] act_d();
    return {7'd0, dx, dy, dhs, dvs, dav, dls, dfs};
  endfunction

  // ---------------- driver ----------------
  // Apply inputs, take one edge, sample 1 time unit later and step the reference.
  task automatic tick(input logic r, input logic c);
    reset = r;
    ce    = c;
    @(posedge clk);
    #1;
    if (r) begin
      smx = 0; smy = 0; dmx = 0; dmy = 0; mframe = 0;
    end else if (c) begin
      if (smx == 19) begin
        smx = 0;
        if (smy == 11) begin
          smy = 0;
          mframe = (mframe + 1) % 256;
        end else begin
          smy++;
        end
      end else begin
        smx++;
      end
      if (dmx == 799) begin
        dmx = 0;
        dmy = (dmy == 524) ? 0 : dmy + 1;
      end else begin
        dmx++;
      end
    end
  endtask

  task automatic run_to(input int tx, input int ty);
    int n;
    n = 0;
    while (!(smx == tx && smy == ty) && n < 400) begin
      tick(1'b0, 1'b1);
      n++;
    end
    check("run_to_pos", {12'd0, sx, sy}, {12'd0, 10'(tx), 10'(ty)});
  endtask

  // ---------------- test ----------------
  initial begin
    logic prev_svs;
    int   hs_low, av_low, vs_low, n;
    logic [31:0] hold_val;

    vecs[0] = '{1'b1, 1'b1, 0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[1] = '{1'b1, 1'b0, 0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[2] = '{1'b0, 1'b1, 1, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 1, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 2, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 3, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[7] = '{1'b0, 1'b0, 0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[8] = '{1'b0, 1'b1, 1, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    // Directed vectors: reset, hold, advance, reset over ce-low.
    for (int i = 0; i < 9; i++) begin
      tick(vecs[i].r, vecs[i].c);
      check($sformatf("vec%0d", i), act_s(),
            pack(vecs[i].x, vecs[i].y, vecs[i].hs, vecs[i].vs, vecs[i].av, vecs[i].ls, vecs[i].fs));
      check($sformatf("vec%0d_dflt", i), act_d(), exp_d(dmx, dmy));
    end

    // Reset mid-frame at (7,5), held for 3 cycles, then release.
    repeat (106) tick(1'b0, 1'b1);
    check("pre_reset_pos", act_s(), pack(7, 5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0));
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b1);
      check($sformatf("reset_cyc%0d", i), act_s(), pack(0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1));
    end
    check("reset_dflt", act_d(), pack(0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1));
    tick(1'b0, 1'b1);
    check("post_reset_first", act_s(), pack(1, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0));
    check("post_reset_dflt", act_d(), pack(1, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0));

    // Free run against the reference: default first line, syncs, vsync edges.
    hs_low = 0; av_low = 0; vs_low = 0;
    prev_svs = svs;
    for (int i = 0; i < 1000; i++) begin
      tick(1'b0, 1'b1);
      check("run_small", act_s(), exp_s(smx, smy));
      check("run_dflt", act_d(), exp_d(dmx, dmy));
      if (i < 800) begin
        if (!dhs) hs_low++;
        if (!dav) av_low++;
      end
      if (i < 240 && !svs) vs_low++;
      if (svs !== prev_svs) check("vsync_edge_x0", {22'd0, sx}, 32'd0);
      prev_svs = svs;
    end
    check("dflt_hsync_low_cycles", hs_low, 96);
    check("dflt_active_low_cycles", av_low, 160);
    check("small_vsync_low_cycles", vs_low, 40);

    // Frame wrap: (19,11) -> (0,0) in a single edge.
    run_to(19, 11);
    check("at_last_pixel", act_s(), pack(19, 11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
`ifdef VGA_TIMING_FRAME_CNT_EN
    hold_val = {24'd0, sframe};
`else
    hold_val = 32'd0;
`endif
    tick(1'b0, 1'b1);
    check("frame_wrap", act_s(), pack(0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1));
`ifdef VGA_TIMING_FRAME_CNT_EN
    check("frame_cnt_step", {24'd0, sframe}, (hold_val + 32'd1) & 32'hff);
`endif

    // frame_start period, 3 consecutive frames.
    for (int k = 0; k < 3; k++) exp_q.push_back(32'd240);
    for (int k = 0; k < 3; k++) begin
      n = 0;
      do begin
        tick(1'b0, 1'b1);
        n++;
      end while (!sfs && n < 1000);
      check($sformatf("frame_period%0d", k), n, exp_q.pop_front());
    end

    // Clock enable held low 5 cycles at (0,10).
    run_to(0, 10);
    check("ce_start", act_s(), pack(0, 10, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0));
    hold_val = act_d();
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 1'b0);
      check($sformatf("ce_hold%0d", i), act_s(), pack(0, 10, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0));
      check($sformatf("ce_hold_dflt%0d", i), act_d(), hold_val);
    end
    tick(1'b0, 1'b1);
    check("ce_resume", act_s(), pack(1, 10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));

`ifdef VGA_TIMING_FRAME_CNT_EN
    // Frame counter across 256 frames: resets to 0, steps, holds, wraps.
    tick(1'b1, 1'b1);
    check("frame_cnt_reset", {24'd0, sframe}, 32'd0);
    for (int f = 1; f <= 256; f++) begin
      repeat (240) tick(1'b0, 1'b1);
      check($sformatf("frame_cnt_f%0d", f), {24'd0, sframe}, 32'(f % 256));
      if (f == 1) begin
        tick(1'b0, 1'b0);
        check("frame_cnt_hold", {24'd0, sframe}, 32'd1);
      end
    end
    check("frame_cnt_model", {24'd0, sframe}, 32'(mframe));
    check("frame_cnt_dflt", {24'd0, dframe}, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Pixel-clock-driven VGA raster timing generator that sits directly upstream of the procedural background renderers. It produces horizontal and vertical pixel positions, sync pulses, the active-video flag and line/frame strobes, all registered and mutually aligned. It drives the `hpos`/`vpos`/`display_on` inputs that the background generators decode for their LFSR enables and frame counters. Default timing is 640x480@60 (800x525 total).

## Interface

Parameters:
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch
- `H_SYNC`, 96, hsync pulse width
- `H_BP`, 48, horizontal back porch
- `V_ACTIVE`, 480, visible lines per frame
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync pulse width (lines)
- `V_BP`, 33, vertical back porch (lines)
- `SYNC_NEG`, 1, 1 = sync pulses active-low, 0 = active-high

Ports:
- `clk`  in  1  pixel clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high reset
- `ce`  in  1  pixel advance enable; low freezes all state and outputs
- `x_px`  out  10  horizontal position, 0..H_TOTAL-1, counts through blanking
- `y_px`  out  10  vertical position, 0..V_TOTAL-1, counts through blanking
- `hsync`  out  1  horizontal sync, polarity per `SYNC_NEG`
- `vsync`  out  1  vertical sync, polarity per `SYNC_NEG`
- `activevideo`  out  1  high when x_px < H_ACTIVE and y_px < V_ACTIVE
- `line_start`  out  1  high when x_px == 0
- `frame_start`  out  1  high when x_px == 0 and y_px == 0
- `frame`  out  8  frame count (only with `VGA_TIMING_FRAME_CNT_EN`)

## Operation

- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Both must be ≤ 1024; elaboration error otherwise.
- Each `ce`-high edge: x_px increments. At x_px == H_TOTAL-1, x_px wraps to 0 and y_px increments. At (H_TOTAL-1, V_TOTAL-1), both wrap to 0.
- `hsync` is asserted for x_px in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]; default is 656..751.
- `vsync` is asserted for whole lines, y_px in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1]; default is 490..491. It changes only together with a y_px change.
- "Asserted" means the level 0 when SYNC_NEG=1 and the level 1 when SYNC_NEG=0.
- All outputs are registers holding the decode of the same pixel. A consumer sees x_px, y_px, syncs, activevideo and strobes for one pixel in the same cycle.
- `ce` low: every output holds its value, including strobes. A strobe therefore stays high for as long as `ce` is held low on that pixel.
- Reset (priority over `ce`): outputs take the pixel (0,0) state.
  - x_px = 0, y_px = 0
  - activevideo = 1, line_start = 1, frame_start = 1
  - hsync and vsync deasserted
  - frame = 0
- Reset mid-frame immediately abandons the current position. There is no partial-line completion.

## Timing

- Reset edge to outputs: 1 cycle. Pixel (0,0) is presented while reset is high and in the first cycle after release.
- The first edge with reset low and ce high presents (1,0).
- Decode latency is zero relative to the counters. Next-state decode is computed from the next counter values and registered alongside them.
- With `ce` tied high: one line is 800 cycles, one frame is 420000 cycles, and the hsync pulse is 96 cycles per line.
- Simultaneous events:
  - Line wrap and frame wrap at (799,524) resolve in one edge to (0,0), with frame_start = 1.
  - Reset and ce high together: reset wins.

## Configuration

- `VGA_TIMING_FRAME_CNT_EN` defined:
  - The `frame` port exists.
  - `frame` increments on every edge that moves the position from (H_TOTAL-1, V_TOTAL-1) to (0,0).
  - It wraps 255 to 0, resets to 0, and holds when `ce` is low.
- Undefined: no `frame` port and no counter logic. All other behaviour is identical.

## Structure

- Shared package `vga_timing_pkg` holds:
  - default timing constants for 640x480@60
  - derived H_TOTAL/V_TOTAL and sync start/end functions
  - the position width constant (10)
  - the polarity localparam helper
- Sub-module `wrap_counter` (parameterised width and terminal value, with `inc` input and `wrap` output) is instantiated twice: horizontal, and vertical with `inc` = horizontal `wrap`.
- Sync/active/strobe decode registers live in the top module.

## Test plan

- Reset: assert reset for 3 cycles mid-frame at (400,300), then release. Required: x_px=0, y_px=0, activevideo=1, frame_start=1, hsync=vsync=1 (SYNC_NEG=1), and the next cycle shows (1,0).
- Line timing: run one line with ce=1. Required: hsync low exactly for x_px 656..751 (96 cycles), activevideo low from x_px=640, and 799 wraps to 0 with y_px incrementing and line_start=1.
- Frame wrap: run to (799,524). Required: next edge gives (0,0), frame_start=1, and frame increments 0→1 with the macro defined. Over 256 frames, frame returns to 0.
- Vsync: across a frame, vsync is low only on lines 490 and 491 (1600 cycles), with edges coincident with x_px=0.
- Clock enable: drop ce for 5 cycles at (0,10). Required: all outputs frozen, line_start held high for 5 cycles, and advance to (1,10) on the first ce-high edge.
- Period check: ce=1 from reset release. Required: frame_start pulses exactly 420000 cycles apart, for 3 consecutive frames.
